pixel_packer: RTL

Sits between the per-pixel colour stage and the 32-bit AXI4-Stream video output. Accepts one 24-bit RGB pixel per handshake and packs every four pixels into three 32-bit words, producing the word stream that the video DMA consumes. Generates start-of-frame (tuser) and end-of-line (tlast) from its own word/line counters. Includes a two-entry output buffer so tready back-pressure never drops data.

---
 rtl/pixel_pkg.sv | 41 ++++
 rtl/stream_fifo2.sv | 58 +++++
 rtl/pixel_packer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel/word types, group constants and packing helpers
package pixel_pkg;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    typedef logic [31:0] word_t;

    localparam int PIX_PER_GROUP   = 4;
    localparam int WORDS_PER_GROUP = 3;

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    // Word completed by the pixel arriving in phase ph; PH0 completes nothing.
    function automatic word_t pack_word(phase_t ph, pixel_t pix, logic [23:0] residue);
        word_t w;
        case (ph)
            PH1:     w = {pix[7:0],  residue[23:0]};
            PH2:     w = {pix[15:0], residue[15:0]};
            PH3:     w = {pix[23:0], residue[7:0]};
            default: w = '0;
        endcase
        return w;
    endfunction

    // Bytes of the pixel arriving in phase ph that are still waiting for a word.
    function automatic logic [23:0] next_residue(phase_t ph, pixel_t pix, logic [23:0] residue);
        logic [23:0] r;
        case (ph)
            PH0:     r = pix;
            PH1:     r = {8'h00,  pix[23:8]};
            PH2:     r = {16'h0000, pix[23:16]};
            default: r = residue;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry valid/ready skid FIFO with a registered head
module stream_fifo2 #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    // A full FIFO can still take a word in the same cycle the head leaves.
    assign m_tvalid = (count_q != 2'd0);
    assign s_tready = (count_q != 2'd2) || m_tready;
    assign m_tdata  = head_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    // Head always holds the oldest word so the output is straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= s_tdata;
                    else                 tail_q <= s_tdata;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= s_tdata;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= s_tdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs 24-bit pixels 4:3 into 32-bit stream words (option: PIXEL_PACKER_SOF_CHECK_EN)
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int X_PIXELS = 960,
    parameter int Y_SIZE   = 720
) (
    input  logic        out_stream_aclk,
    input  logic        axi_resetn,
    input  logic [23:0] in_pixel,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tuser,
    output logic        out_stream_tlast,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        err_sync
);

    localparam int WPL  = X_PIXELS * WORDS_PER_GROUP / PIX_PER_GROUP;
    localparam int XW_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int Y_W  = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW_W-1:0] XW_LAST = XW_W'(WPL - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(Y_SIZE - 1);

    phase_t          phase_q, phase_d;
    logic [23:0]     residue_q, residue_d;
    logic [XW_W-1:0] xw_q, xw_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            err_q;

    pixel_t      pix;
    logic        accept;
    logic        resync;
    logic        push;
    logic        fifo_s_ready;
    logic [33:0] push_data;
    logic [33:0] head_data;

    assign pix      = pixel_t'(in_pixel);
    // Phase 0 only loads the residue, so it never needs FIFO space.
    assign in_ready = (phase_q == PH0) || fifo_s_ready;
    assign accept   = in_valid && in_ready;

`ifdef PIXEL_PACKER_SOF_CHECK_EN
    assign resync = accept && in_sof && ((phase_q != PH0) || (xw_q != '0) || (y_q != '0));
`else
    logic unused_sof;
    assign unused_sof = in_sof;
    assign resync     = 1'b0;
`endif

    assign push      = accept && (phase_q != PH0) && !resync;
    assign push_data = {pack_word(phase_q, pix, residue_q),
                        (xw_q == '0) && (y_q == '0),
                        (xw_q == XW_LAST)};

    // Next-state for group phase, residue bytes and the word/line position.
    always_comb begin
        phase_d   = phase_q;
        residue_d = residue_q;
        xw_d      = xw_q;
        y_d       = y_q;
        if (resync) begin
            phase_d   = PH1;
            residue_d = pix;
            xw_d      = '0;
            y_d       = '0;
        end else if (accept) begin
            phase_d   = phase_t'(phase_q + 2'd1);
            residue_d = next_residue(phase_q, pix, residue_q);
            if (push) begin
                if (xw_q == XW_LAST) begin
                    xw_d = '0;
                    y_d  = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    xw_d = xw_q + 1'b1;
                end
            end
        end
    end

    // Packing state registers; the sync error flag is sticky until reset.
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            phase_q   <= PH0;
            residue_q <= '0;
            xw_q      <= '0;
            y_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            residue_q <= residue_d;
            xw_q      <= xw_d;
            y_q       <= y_d;
            err_q     <= err_q || resync;
        end
    end

    stream_fifo2 #(
        .WIDTH (34)
    ) u_fifo (
        .clk      (out_stream_aclk),
        .rst_n    (axi_resetn),
        .s_tdata  (push_data),
        .s_tvalid (push),
        .s_tready (fifo_s_ready),
        .m_tdata  (head_data),
        .m_tvalid (out_stream_tvalid),
        .m_tready (out_stream_tready)
    );

    assign out_stream_tdata = head_data[33:2];
    assign out_stream_tuser = head_data[1];
    assign out_stream_tlast = head_data[0];
    assign out_stream_tkeep = 4'hF;
    assign err_sync         = err_q;

endmodule
